// File: rtl/bpu_gshare_btb.sv
// bpu_gshare_btb: tagged direct-mapped BTB plus a bimodal/gshare 2-bit PHT predictor,
// with a reset-time PHT clear sweep and a saturating misprediction counter.
module bpu_gshare_btb #(
   parameter int         BTB_IDX_BITS = 6,
   parameter int         PHT_IDX_BITS = 12,
   parameter int         GHR_BITS     = 12,
   parameter int         MODE         = 1,
   parameter logic [1:0] CNT_INIT     = 2'b01
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] old_PC,
   input  logic        predict_en,
   output logic [31:0] new_PC,
   output logic        predict_jump,
   input  logic        upd_en,
   input  logic [31:0] upd_addr,
   input  logic        upd_jumpinst,
   input  logic        upd_jump,
   input  logic        upd_predfail,
   input  logic [31:0] upd_target,
   output logic        init_done,
   output logic [31:0] mispred_cnt
);
   localparam int NB = 1 << BTB_IDX_BITS;
   localparam int NP = 1 << PHT_IDX_BITS;
   localparam int TW = 30 - BTB_IDX_BITS;
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   logic [0:0]              state;
   logic [PHT_IDX_BITS-1:0] ptr;
   logic [1:0]              pht [NP];
   logic [NB-1:0]           btb_v;
   logic [TW-1:0]           btb_tag [NB];
   logic [31:0]             btb_tgt [NB];
   logic [GHR_BITS-1:0]     ghr;
   logic [PHT_IDX_BITS-1:0] hist, pidx_p, pidx_u;
   logic [BTB_IDX_BITS-1:0] bi_p, bi_u;
   logic [1:0]              cnt_u;
   logic                    hit, taken, train, unused_bits;

   assign hist         = MODE == 1 ? PHT_IDX_BITS'(ghr) : '0;
   assign pidx_p       = old_PC[PHT_IDX_BITS+1:2] ^ hist;
   assign pidx_u       = upd_addr[PHT_IDX_BITS+1:2] ^ hist;
   assign bi_p         = old_PC[BTB_IDX_BITS+1:2];
   assign bi_u         = upd_addr[BTB_IDX_BITS+1:2];
   assign hit          = btb_v[bi_p] && btb_tag[bi_p] == old_PC[31:BTB_IDX_BITS+2];
   assign taken        = state == RUN && hit && pht[pidx_p][1];
   assign predict_jump = predict_en && taken;
   assign new_PC       = !predict_en ? old_PC : taken ? btb_tgt[bi_p] : old_PC + 32'd4;
   assign train        = state == RUN && upd_en && (upd_jumpinst || upd_jump);
   assign cnt_u        = pht[pidx_u];
   assign init_done    = state == RUN;
   assign unused_bits  = ^upd_addr[1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= CLEAR;
         ptr         <= '0;
         ghr         <= '0;
         btb_v       <= '0;
         mispred_cnt <= '0;
      end else begin
         if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) state <= RUN;
         end
         if (train) ghr <= GHR_BITS'({ghr, upd_jump});
         if (train && upd_jump) btb_v[bi_u] <= 1'b1;
         if (state == RUN && upd_en && upd_predfail && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
      end
   end

   // Table storage is not reset: the sweep rewrites the PHT, BTB payload is gated by btb_v.
   always_ff @(posedge clk) begin
      if (state == CLEAR) pht[ptr] <= CNT_INIT;
      else if (train) pht[pidx_u] <= upd_jump ? (cnt_u == 2'd3 ? cnt_u : cnt_u + 2'd1)
                                             : (cnt_u == 2'd0 ? cnt_u : cnt_u - 2'd1);
      if (train && upd_jump) begin
         btb_tag[bi_u] <= upd_addr[31:BTB_IDX_BITS+2];
         btb_tgt[bi_u] <= upd_target;
      end
   end
endmodule

// File: tb/tb_bpu_gshare_btb.sv
// tb_bpu_gshare_btb: bimodal and gshare instances driven in lockstep and checked
// against a table-level reference model of the predictor.
module tb_bpu_gshare_btb;
   logic        clk = 0, resetn = 0, predict_en = 0, upd_en = 0;
   logic        upd_jumpinst = 0, upd_jump = 0, upd_predfail = 0;
   logic [31:0] old_PC = 0, upd_addr = 0, upd_target = 0;
   logic [31:0] new_pc0, new_pc1, mis0, mis1;
   logic        pj0, pj1, id0, id1;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   bpu_gshare_btb #(.BTB_IDX_BITS(4), .PHT_IDX_BITS(4), .GHR_BITS(2), .MODE(0), .CNT_INIT(2'b01)) u0 (
      .clk(clk), .resetn(resetn), .old_PC(old_PC), .predict_en(predict_en), .new_PC(new_pc0),
      .predict_jump(pj0), .upd_en(upd_en), .upd_addr(upd_addr), .upd_jumpinst(upd_jumpinst),
      .upd_jump(upd_jump), .upd_predfail(upd_predfail), .upd_target(upd_target),
      .init_done(id0), .mispred_cnt(mis0));

   bpu_gshare_btb #(.BTB_IDX_BITS(4), .PHT_IDX_BITS(4), .GHR_BITS(2), .MODE(1), .CNT_INIT(2'b01)) u1 (
      .clk(clk), .resetn(resetn), .old_PC(old_PC), .predict_en(predict_en), .new_PC(new_pc1),
      .predict_jump(pj1), .upd_en(upd_en), .upd_addr(upd_addr), .upd_jumpinst(upd_jumpinst),
      .upd_jump(upd_jump), .upd_predfail(upd_predfail), .upd_target(upd_target),
      .init_done(id1), .mispred_cnt(mis1));

   // Reference model: m=0 bimodal, m=1 gshare; 16-entry BTB and PHT, 2-bit history.
   int          cyc;
   bit          m_v   [2][16];
   logic [31:0] m_tag [2][16];
   logic [31:0] m_tgt [2][16];
   int          m_pht [2][16];
   int          m_ghr [2];
   logic [31:0] m_cnt [2];

   function automatic int pidx(int m, logic [31:0] pc);
      return int'((pc >> 2) % 16) ^ (m == 1 ? m_ghr[m] : 0);
   endfunction

   task automatic model_reset;
      cyc = 0;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) begin
            m_v[m][i]   = 0;
            m_pht[m][i] = 1;
         end
         m_ghr[m] = 0;
         m_cnt[m] = 0;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(int m, logic [31:0] npc, logic pj, logic id, logic [31:0] mc);
      bit run;
      int bi;
      bit hit, t;
      logic [31:0] exp_pc;
      run    = resetn && cyc >= 16;
      bi     = int'((old_PC >> 2) % 16);
      hit    = m_v[m][bi] && m_tag[m][bi] == (old_PC >> 6);
      t      = predict_en && run && hit && m_pht[m][pidx(m, old_PC)] >= 2;
      exp_pc = !predict_en ? old_PC : t ? m_tgt[m][bi] : old_PC + 32'd4;
      chk($sformatf("predict_jump[m%0d t=%0t]", m, $time), {31'b0, pj}, {31'b0, t});
      chk($sformatf("new_PC[m%0d t=%0t]", m, $time), npc, exp_pc);
      chk($sformatf("init_done[m%0d t=%0t]", m, $time), {31'b0, id}, {31'b0, run});
      chk($sformatf("mispred_cnt[m%0d t=%0t]", m, $time), mc, m_cnt[m]);
   endtask

   task automatic model_update;
      bit run;
      int i;
      run = cyc >= 16;
      for (int m = 0; m < 2; m++) begin
         if (run && upd_en && upd_predfail && m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m]++;
         if (run && upd_en && (upd_jumpinst || upd_jump)) begin
            i = pidx(m, upd_addr);
            if (upd_jump) begin
               if (m_pht[m][i] < 3) m_pht[m][i]++;
               m_v[m][(upd_addr >> 2) % 16]   = 1;
               m_tag[m][(upd_addr >> 2) % 16] = upd_addr >> 6;
               m_tgt[m][(upd_addr >> 2) % 16] = upd_target;
            end else if (m_pht[m][i] > 0) m_pht[m][i]--;
            m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_jump)) % 4;
         end
      end
      cyc++;
   endtask

   // Called just after a falling edge: drive, check pre-edge outputs, advance model at the rising edge.
   task automatic step(bit pe, logic [31:0] pc, bit ue, logic [31:0] ua, bit ji, bit j, bit pf, logic [31:0] tg);
      predict_en = pe; old_PC = pc; upd_en = ue; upd_addr = ua;
      upd_jumpinst = ji; upd_jump = j; upd_predfail = pf; upd_target = tg;
      #1;
      check_outputs(0, new_pc0, pj0, id0, mis0);
      check_outputs(1, new_pc1, pj1, id1, mis1);
      @(posedge clk);
      if (resetn) model_update();
      @(negedge clk);
   endtask

   task automatic pred(logic [31:0] pc);
      step(1, pc, 0, 32'h0, 0, 0, 0, 32'h0);
   endtask

   task automatic upd(logic [31:0] a, bit j, logic [31:0] tg);
      step(0, 32'h0, 1, a, 1, j, 0, tg);
   endtask

   task automatic rand_steps(int n);
      for (int k = 0; k < n; k++)
         step(bit'($urandom_range(0, 1)), 32'h1000 + ($urandom_range(0, 31) << 2),
              bit'($urandom_range(0, 1)), 32'h1000 + ($urandom_range(0, 31) << 2),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      pred(32'h1000);
      step(0, 32'h1000, 0, 32'h0, 0, 0, 0, 32'h0);
      resetn = 1;
      for (int k = 0; k < 16; k++) step(1, 32'h1000, 1, 32'h1000, 1, 1, 1, 32'h2000);
      pred(32'h1000);
      step(0, 32'h1000, 0, 32'h0, 0, 0, 0, 32'h0);
      upd(32'h1000, 1, 32'h2000);
      pred(32'h1000);
      upd(32'h1000, 0, 32'h0);
      upd(32'h1000, 0, 32'h0);
      pred(32'h1000);
      upd(32'h1000, 1, 32'h2000);
      upd(32'h1000, 1, 32'h2000);
      pred(32'h1000);
      pred(32'h1100);
      for (int k = 0; k < 8; k++) upd(32'h1000, k % 2 == 0, 32'h2000);
      pred(32'h1000);
      step(1, 32'h1000, 1, 32'h1000, 1, 1, 0, 32'h3000);
      pred(32'h1000);
      for (int k = 0; k < 5; k++) step(0, 32'h0, 1, 32'h0, 0, 0, 1, 32'h0);
      pred(32'h1000);
      chk("mispred_five", mis0, 32'd5);
      rand_steps(400);
      resetn = 0;
      model_reset();
      step(1, 32'h1040, 0, 32'h0, 0, 0, 0, 32'h0);
      step(1, 32'h1000, 1, 32'h1000, 1, 1, 1, 32'h2000);
      resetn = 1;
      rand_steps(200);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
